// File: rtl/sparse_read_expander.sv
// Sparse read expander: walks a compacted {idx,value} memory and rebuilds
// the dense stream, zero-filling suppressed positions.
//
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start        : 1-cycle pulse, latches num_entries/dense_len when idle
//   num_entries  : number of stored entries (addr 0 upward)
//   dense_len    : number of dense words to emit
//   rd_en/addr   : compacted memory read strobe and address
//   rd_data      : {idx,value}, valid one cycle after rd_en
//   out_*        : dense word stream, valid/ready handshake
//   busy/done/err: run status; err is sticky until the next accepted start
module sparse_read_expander #(
    parameter int DATA_W = 48,
    parameter int IDX_W  = 10,
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W:0]         num_entries,
    input  logic [IDX_W:0]          dense_len,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [IDX_W+DATA_W-1:0] rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } state_t;

    state_t state;

    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   ptr;
    logic [IDX_W:0]    len;
    logic [IDX_W:0]    pos;
    logic [IDX_W-1:0]  ent_idx;
    logic [DATA_W-1:0] ent_val;
    logic              have_ent;

    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_val;
    logic [IDX_W:0]    rd_idx_w;
    logic [IDX_W:0]    ent_idx_w;
    logic [IDX_W:0]    pos_nxt;
    logic [IDX_W:0]    len_m1;
    logic [ADDR_W:0]   ptr_nxt;
    logic              last;
    logic              consumed;
    logic              more;
    logic              left_over;
    logic              nxt_hit;
    logic              hs;

    assign rd_idx    = rd_data[IDX_W+DATA_W-1:DATA_W];
    assign rd_val    = rd_data[DATA_W-1:0];
    assign rd_idx_w  = {1'b0, rd_idx};
    assign ent_idx_w = {1'b0, ent_idx};
    assign pos_nxt   = pos + 1'b1;
    assign len_m1    = len - 1'b1;
    assign ptr_nxt   = ptr + 1'b1;
    assign last      = (pos == len_m1);
    assign consumed  = have_ent && (ent_idx_w == pos);
    // Another entry remains to be fetched after the current one.
    assign more      = (ptr_nxt < cnt);
    // Guard: entries still unread when the dense stream ends.
    assign left_over = have_ent ? (!consumed || more) : (ptr < cnt);
    // Held entry lands on the next dense position.
    assign nxt_hit   = have_ent && !consumed && (ent_idx_w == pos_nxt);
    assign hs        = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            len       <= '0;
            pos       <= '0;
            ptr       <= '0;
            ent_idx   <= '0;
            ent_val   <= '0;
            have_ent  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt      <= num_entries;
                        len      <= dense_len;
                        pos      <= '0;
                        ptr      <= '0;
                        have_ent <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        if (dense_len == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (num_entries == '0) begin
                            out_valid <= 1'b1;
                            out_idx   <= '0;
                            out_data  <= '0;
                            state     <= EMIT;
                        end else begin
                            rd_en   <= 1'b1;
                            rd_addr <= '0;
                            state   <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    rd_en <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    ent_idx  <= rd_idx;
                    ent_val  <= rd_val;
                    have_ent <= 1'b1;
                    if (rd_idx_w < pos || rd_idx_w >= len) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        out_valid <= 1'b1;
                        out_idx   <= pos[IDX_W-1:0];
                        out_data  <= (rd_idx_w == pos) ? rd_val : '0;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (hs) begin
                        if (last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                            if (left_over) begin
                                err <= 1'b1;
                            end
                        end else begin
                            pos     <= pos_nxt;
                            out_idx <= pos_nxt[IDX_W-1:0];
                            if (consumed) begin
                                ptr      <= ptr_nxt;
                                have_ent <= 1'b0;
                                if (more) begin
                                    out_valid <= 1'b0;
                                    rd_en     <= 1'b1;
                                    rd_addr   <= ptr_nxt[ADDR_W-1:0];
                                    state     <= FETCH;
                                end else begin
                                    out_data <= '0;
                                end
                            end else begin
                                out_data <= nxt_hit ? ent_val : '0;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_read_expander.sv
// Scoreboard bench for sparse_read_expander: directed runs push expected
// dense words, a negedge monitor pops and compares on each handshake.
module tb_sparse_read_expander;

    localparam int DW = 48;
    localparam int IW = 10;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   num_entries;
    logic [IW:0]   dense_len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [IW+DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          busy;
    logic          done;
    logic          err;

    sparse_read_expander dut (
        .clk(clk), .reset(reset), .start(start),
        .num_entries(num_entries), .dense_len(dense_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [IW+DW-1:0] mem [0:1023];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    logic [IW+DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    logic hold_chk = 1'b0;
    logic [DW-1:0] h_data;
    logic [IW-1:0] h_idx;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(int idx, logic [DW-1:0] d);
        logic [IW-1:0] i;
        i = idx[IW-1:0];
        exp_q.push_back({i, d});
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_chk = 1'b0;
        end else begin
            if (rd_en) rd_cnt++;
            if (done) done_cnt++;
            if (hold_chk) begin
                chk("hold_data", 64'(out_data), 64'(h_data));
                chk("hold_idx", 64'(out_idx), 64'(h_idx));
            end
            hold_chk = out_valid && !out_ready;
            h_data = out_data;
            h_idx = out_idx;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'({out_idx, out_data}), 64'hDEAD);
                end else begin
                    chk("out_word", 64'({out_idx, out_data}),
                        64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic go(string name, int len, int cnt, logic exp_err,
                      int exp_rd, int exp_lat);
        int lat;
        int i;
        @(posedge clk); #1;
        rd_cnt = 0;
        done_cnt = 0;
        num_entries = cnt[AW:0];
        dense_len = len[IW:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!out_valid && !done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        i = 0;
        while (done_cnt == 0 && i < 500) begin
            @(posedge clk); #1;
            i++;
        end
        chk({name, "_done_seen"}, 64'(i < 500), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({name, "_err"}, 64'(err), 64'(exp_err));
        chk({name, "_reads"}, 64'(rd_cnt), 64'(exp_rd));
        chk({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic load_t2();
        mem[0] = {10'd1, 48'h000000000A5A};
        mem[1] = {10'd3, 48'h7FF000000001};
        push(0, '0); push(1, 48'h000000000A5A); push(2, '0);
        push(3, 48'h7FF000000001); push(4, '0);
    endtask

    task automatic chk_zero(string name);
        chk({name, "_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_rd_en"}, 64'(rd_en), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_done"}, 64'(done), 64'd0);
        chk({name, "_err"}, 64'(err), 64'd0);
        chk({name, "_outs"}, 64'({rd_addr, out_data, out_idx} != '0), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_entries = '0;
        dense_len = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_zero("reset");

        // T1: zero-fill only
        for (int k = 0; k < 4; k++) push(k, '0);
        go("t1", 4, 0, 1'b0, 0, 1);

        // T2: two sparse entries
        load_t2();
        go("t2", 5, 2, 1'b0, 2, 3);

        // T3: stall at idx 1
        load_t2();
        fork
            go("t3", 5, 2, 1'b0, 2, 3);
            begin
                for (int k = 0; k < 50; k++) begin
                    @(posedge clk); #2;
                    if (out_valid && out_idx == 1) break;
                end
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join

        // T4: out-of-order entry
        mem[0] = {10'd2, 48'h123456789ABC};
        mem[1] = {10'd1, 48'h000000000001};
        push(0, '0); push(1, '0); push(2, 48'h123456789ABC);
        go("t4", 4, 2, 1'b1, 2, 3);

        // T5: empty run, then start while busy
        go("t5a", 0, 3, 1'b0, 0, 1);
        for (int k = 0; k < 3; k++) push(k, '0);
        fork
            go("t5b", 3, 0, 1'b0, 0, 1);
            begin
                repeat (3) @(posedge clk);
                #2 start = 1'b1;
                dense_len = 11'd7;
                num_entries = 11'd2;
                @(posedge clk);
                #2 start = 1'b0;
            end
        join

        // T7: stored -0 emitted verbatim, then idx >= len
        mem[0] = {10'd0, 48'h800000000000};
        mem[1] = {10'd5, 48'h000000000077};
        push(0, 48'h800000000000);
        go("t7", 3, 2, 1'b1, 2, 3);

        // T6: reset in the middle of EMIT
        for (int k = 0; k < 6; k++) push(k, '0);
        @(posedge clk); #1;
        num_entries = '0;
        dense_len = 11'd6;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_q.delete();
        chk_zero("t6_reset");
        @(posedge clk); #1;
        chk("t6_idle_valid", 64'(out_valid), 64'd0);
        load_t2();
        go("t6_rerun", 5, 2, 1'b0, 2, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
